pipe_unpack: RTL and testbench

//  Receive end of the pipe word stream: accepts W_DATA-wide words over valid/ready
//  and emits them as W_DATA/W_BEAT narrow beats, LSB beat first, over valid/ready.
//  Two-entry buffer (active + next) sustains full beat-rate throughput with a

---
 rtl/pipe_unpack.sv | 141 ++++++++++++++
 tb/tb_pipe_unpack.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_unpack.sv
// Wide-to-narrow word unpacker: W_DATA words in, W_BEAT beats out (LSB beat first),
// with a two-entry (active + next) buffer so the input side keeps beat-rate throughput.
module pipe_unpack #(
  parameter int W_DATA = 32,
  parameter int W_BEAT = 8
) (
  input  logic              i_clk,
  input  logic              resetn,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [W_DATA-1:0] i_data,
  input  logic              i_last,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [W_BEAT-1:0] o_data,
  output logic              o_last,
  output logic              o_busy
);

  localparam int N_BEATS = W_DATA / W_BEAT;
  localparam int W_CNT   = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam logic [W_CNT-1:0] CNT_MAX = W_CNT'(N_BEATS - 1);

  localparam logic [1:0] ST_EMPTY  = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_FULL   = 2'd2;

  if ((W_DATA % W_BEAT) != 0) begin : g_bad_width
    $error("pipe_unpack: W_DATA must be a multiple of W_BEAT");
  end

  logic [1:0]        state_q, state_d;
  logic [W_CNT-1:0]  cnt_q, cnt_d;
  logic [W_DATA-1:0] active_q, active_d;
  logic              active_last_q, active_last_d;
  logic [W_DATA-1:0] next_q, next_d;
  logic              next_last_q, next_last_d;
  logic              ready_q, ready_d;

  logic accept_s;
  logic emit_s;
  logic wrap_s;
  logic [N_BEATS-1:0][W_BEAT-1:0] beats_s;

  assign accept_s = i_valid & ready_q;
  assign emit_s   = (state_q != ST_EMPTY) & i_ready;
  assign wrap_s   = emit_s & (cnt_q == CNT_MAX);
  assign beats_s  = active_q;

  // Next-state: buffer occupancy, beat counter and word registers.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    active_d      = active_q;
    active_last_d = active_last_q;
    next_d        = next_q;
    next_last_d   = next_last_q;

    if (emit_s) begin
      if (wrap_s) begin
        cnt_d = {W_CNT{1'b0}};
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = cnt_q;
    end

    case (state_q)
      ST_EMPTY: begin
        if (accept_s) begin
          active_d      = i_data;
          active_last_d = i_last;
          cnt_d         = {W_CNT{1'b0}};
          state_d       = ST_ACTIVE;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_ACTIVE: begin
        // A new word arriving with the final beat goes straight into active: no bubble.
        if (wrap_s && accept_s) begin
          active_d      = i_data;
          active_last_d = i_last;
          state_d       = ST_ACTIVE;
        end else if (wrap_s) begin
          state_d = ST_EMPTY;
        end else if (accept_s) begin
          next_d      = i_data;
          next_last_d = i_last;
          state_d     = ST_FULL;
        end else begin
          state_d = ST_ACTIVE;
        end
      end
      ST_FULL: begin
        if (wrap_s) begin
          active_d      = next_q;
          active_last_d = next_last_q;
          state_d       = ST_ACTIVE;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
        cnt_d   = {W_CNT{1'b0}};
      end
    endcase

    ready_d = (state_d != ST_FULL);
  end

  // State registers; reset drops any in-flight words.
  always_ff @(posedge i_clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_EMPTY;
      cnt_q         <= {W_CNT{1'b0}};
      active_q      <= {W_DATA{1'b0}};
      active_last_q <= 1'b0;
      next_q        <= {W_DATA{1'b0}};
      next_last_q   <= 1'b0;
      ready_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      active_q      <= active_d;
      active_last_q <= active_last_d;
      next_q        <= next_d;
      next_last_q   <= next_last_d;
      ready_q       <= ready_d;
    end
  end

  assign o_ready = ready_q;
  assign o_valid = (state_q != ST_EMPTY);
  assign o_busy  = (state_q != ST_EMPTY);
  assign o_data  = beats_s[cnt_q];
  assign o_last  = active_last_q & (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_pipe_unpack.sv
// Directed bench for pipe_unpack: 32/8 instance for the main scenarios and a
// 16/16 instance for the single-beat-per-word case.
module tb_pipe_unpack;

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid, rdy_in, last;
  logic [31:0] data;
  logic        o_ready, o_valid, o_last, o_busy;
  logic [7:0]  o_data;

  logic        v1, r1, l1;
  logic [15:0] d1;
  logic        o_ready1, o_valid1, o_last1, o_busy1;
  logic [15:0] o_data1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_unpack #(.W_DATA(32), .W_BEAT(8)) u_dut (
    .i_clk(clk), .resetn(resetn), .i_valid(valid), .o_ready(o_ready),
    .i_data(data), .i_last(last), .o_valid(o_valid), .i_ready(rdy_in),
    .o_data(o_data), .o_last(o_last), .o_busy(o_busy)
  );

  pipe_unpack #(.W_DATA(16), .W_BEAT(16)) u_dut1 (
    .i_clk(clk), .resetn(resetn), .i_valid(v1), .o_ready(o_ready1),
    .i_data(d1), .i_last(l1), .o_valid(o_valid1), .i_ready(r1),
    .o_data(o_data1), .o_last(o_last1), .o_busy(o_busy1)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; all driving and sampling happens 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_b;
  logic       rdy_s;
  int         widx;
  logic [31:0] words [3];

  initial begin
    resetn = 1'b0; valid = 1'b0; rdy_in = 1'b1; last = 1'b0; data = 32'h0;
    v1 = 1'b0; r1 = 1'b1; l1 = 1'b0; d1 = 16'h0;
    cyc(); cyc();
    chk_eq("rst_valid", {31'd0, o_valid}, 32'd0);
    chk_eq("rst_ready", {31'd0, o_ready}, 32'd1);
    chk_eq("rst_busy",  {31'd0, o_busy},  32'd0);
    chk_eq("rst_data",  {24'd0, o_data},  32'd0);
    chk_eq("rst_last",  {31'd0, o_last},  32'd0);
    resetn = 1'b1;
    cyc();

    // 1: reset mid-word at count 2
    valid = 1'b1; data = 32'h4433_2211; last = 1'b0;
    cyc(); valid = 1'b0;
    chk_eq("t1_b0", {24'd0, o_data}, 32'h11);
    cyc(); cyc();
    chk_eq("t1_b2", {24'd0, o_data}, 32'h33);
    resetn = 1'b0;
    #1;
    chk_eq("t1_rst_valid", {31'd0, o_valid}, 32'd0);
    chk_eq("t1_rst_ready", {31'd0, o_ready}, 32'd1);
    chk_eq("t1_rst_busy",  {31'd0, o_busy},  32'd0);
    cyc(); resetn = 1'b1; cyc();
    valid = 1'b1; data = 32'h8877_6655; last = 1'b1;
    cyc(); valid = 1'b0;
    chk_eq("t1_restart_b0", {24'd0, o_data}, 32'h55);
    cyc(); cyc(); cyc(); cyc();
    chk_eq("t1_drained", {31'd0, o_valid}, 32'd0);

    // 2: single word, one beat per cycle, o_last only with DD
    valid = 1'b1; data = 32'hDDCC_BBAA; last = 1'b1;
    cyc(); valid = 1'b0; data = 32'hFFFF_FFFF; last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_b = 8'hAA + 8'(8'h11 * i);
      chk_eq("t2_valid", {31'd0, o_valid}, 32'd1);
      chk_eq("t2_data", {24'd0, o_data}, {24'd0, exp_b});
      chk_eq("t2_last", {31'd0, o_last}, (i == 3) ? 32'd1 : 32'd0);
      cyc();
    end
    chk_eq("t2_idle", {31'd0, o_valid}, 32'd0);
    chk_eq("t2_busy", {31'd0, o_busy}, 32'd0);

    // 3: three words streamed back to back
    words[0] = 32'h0302_0100; words[1] = 32'h1312_1110; words[2] = 32'h2322_2120;
    widx = 0; valid = 1'b1; data = words[0]; last = 1'b0;
    rdy_s = o_ready;
    cyc();
    widx = 1; data = words[1];
    for (int t = 0; t < 12; t++) begin
      exp_b = 8'((t / 4) * 16 + (t % 4));
      chk_eq("t3_valid", {31'd0, o_valid}, 32'd1);
      chk_eq("t3_data", {24'd0, o_data}, {24'd0, exp_b});
      if (t == 1) chk_eq("t3_full_ready", {31'd0, o_ready}, 32'd0);
      rdy_s = o_ready;
      cyc();
      if (rdy_s && valid) begin
        widx++;
        if (widx < 3) begin
          data = words[widx]; last = (widx == 2);
        end else begin
          valid = 1'b0;
        end
      end
    end
    chk_eq("t3_all_taken", widx, 32'd3);
    chk_eq("t3_idle", {31'd0, o_valid}, 32'd0);

    // 4: backpressure at beat 1
    valid = 1'b1; data = 32'hDDCC_BBAA; last = 1'b0;
    cyc(); valid = 1'b0;
    chk_eq("t4_b0", {24'd0, o_data}, 32'hAA);
    cyc();
    rdy_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk_eq("t4_hold_data", {24'd0, o_data}, 32'hBB);
      chk_eq("t4_hold_valid", {31'd0, o_valid}, 32'd1);
    end
    rdy_in = 1'b1;
    cyc();
    chk_eq("t4_resume", {24'd0, o_data}, 32'hCC);
    cyc();
    chk_eq("t4_b3", {24'd0, o_data}, 32'hDD);
    cyc();
    chk_eq("t4_idle", {31'd0, o_valid}, 32'd0);

    // 5: fill to FULL under backpressure; third word waits
    rdy_in = 1'b0;
    valid = 1'b1; data = 32'h0D0C_0B0A; last = 1'b0;
    cyc();
    data = 32'h1D1C_1B1A;
    cyc();
    data = 32'h2D2C_2B2A; last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_eq("t5_full_ready", {31'd0, o_ready}, 32'd0);
      chk_eq("t5_full_busy", {31'd0, o_busy}, 32'd1);
      chk_eq("t5_full_data", {24'd0, o_data}, 32'h0A);
    end
    rdy_in = 1'b1;
    for (int t = 1; t < 12; t++) begin
      cyc();
      exp_b = 8'((t / 4) * 16 + 8'h0A + (t % 4));
      chk_eq("t5_data", {24'd0, o_data}, {24'd0, exp_b});
      if (t == 4) chk_eq("t5_ready_back", {31'd0, o_ready}, 32'd1);
      if (t == 5) begin
        chk_eq("t5_refull", {31'd0, o_ready}, 32'd0);
        valid = 1'b0;
      end
      if (t == 11) chk_eq("t5_last", {31'd0, o_last}, 32'd1);
    end
    cyc();
    chk_eq("t5_idle", {31'd0, o_valid}, 32'd0);

    // 6: single-beat words on the 16/16 instance
    v1 = 1'b1; d1 = 16'h1234; l1 = 1'b0;
    cyc();
    chk_eq("t6_w0_valid", {31'd0, o_valid1}, 32'd1);
    chk_eq("t6_w0_data", {16'd0, o_data1}, 32'h1234);
    chk_eq("t6_w0_last", {31'd0, o_last1}, 32'd0);
    d1 = 16'h5678; l1 = 1'b1;
    cyc(); v1 = 1'b0;
    chk_eq("t6_w1_data", {16'd0, o_data1}, 32'h5678);
    chk_eq("t6_w1_last", {31'd0, o_last1}, 32'd1);
    cyc();
    chk_eq("t6_idle", {31'd0, o_valid1}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
